// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the in-order RV32 core: per-stage valid/rd tracking,
// load-use/latency interlock, redirect flush of ID and youngest-first forwarding into EX.
module pipe_hazard_ctrl #(
    parameter int unsigned NSTAGES  = 2,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ALU_LAT  = 2,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    icache_valid,
    input  logic                    dcache_valid,
    input  logic                    id_valid,
    input  logic [4:0]              id_rs1,
    input  logic [4:0]              id_rs2,
    input  logic                    id_use_rs1,
    input  logic                    id_use_rs2,
    input  logic [4:0]              id_rd,
    input  logic                    id_wen,
    input  logic                    id_is_load,
    input  logic                    ex_redirect,
    input  logic [XLEN-1:0]         ex_reg1_rf,
    input  logic [XLEN-1:0]         ex_reg2_rf,
    input  logic [NSTAGES*XLEN-1:0] stage_wdata,
    output logic                    pipeline_en,
    output logic                    id_stall,
    output logic                    id_flush,
    output logic [XLEN-1:0]         ex_reg1,
    output logic [XLEN-1:0]         ex_reg2,
    output logic [NSTAGES-1:0]      stage_valid,
    output logic                    wb_wen,
    output logic [4:0]              wb_rd,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    logic [NSTAGES:1] st_valid;
    logic             st_wen     [1:NSTAGES];
    logic             st_is_load [1:NSTAGES];
    logic             st_use_rs1 [1:NSTAGES];
    logic             st_use_rs2 [1:NSTAGES];
    logic [4:0]       st_rd      [1:NSTAGES];
    logic [4:0]       st_rs1     [1:NSTAGES];
    logic [4:0]       st_rs2     [1:NSTAGES];

    logic redirect;
    logic hit1, hit2;
    logic haz1, haz2;
    logic fwd1, fwd2;
    logic id_accept;

    // EX's own result slice is never forwarded back into EX.
    logic unused_ex_wdata;
    assign unused_ex_wdata = ^stage_wdata[XLEN-1:0];

    assign pipeline_en = icache_valid && dcache_valid;
    assign redirect    = ex_redirect && st_valid[1];
    assign id_flush    = id_valid && redirect;
    assign id_stall    = id_valid && (haz1 || haz2) && !redirect;
    assign id_accept   = id_valid && !id_stall && !id_flush;

    assign stage_valid = st_valid;
    assign wb_wen      = st_valid[NSTAGES] && st_wen[NSTAGES];
    assign wb_rd       = st_rd[NSTAGES];

    // Only the youngest in-flight writer of a source decides the interlock;
    // a producer in the last stage is covered by the write-first regfile.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int unsigned s = 1; s < NSTAGES; s++) begin
            if (!hit1 && id_use_rs1 && (id_rs1 != 5'd0) && st_valid[s] && st_wen[s]
                && (st_rd[s] == id_rs1)) begin
                hit1 = 1'b1;
                haz1 = ((s + 1) < (st_is_load[s] ? LOAD_LAT : ALU_LAT));
            end
            if (!hit2 && id_use_rs2 && (id_rs2 != 5'd0) && st_valid[s] && st_wen[s]
                && (st_rd[s] == id_rs2)) begin
                hit2 = 1'b1;
                haz2 = ((s + 1) < (st_is_load[s] ? LOAD_LAT : ALU_LAT));
            end
        end
    end

    always_comb begin
        fwd1    = 1'b0;
        fwd2    = 1'b0;
        ex_reg1 = ex_reg1_rf;
        ex_reg2 = ex_reg2_rf;
        for (int unsigned s = 2; s <= NSTAGES; s++) begin
            if (!fwd1 && st_use_rs1[1] && (st_rs1[1] != 5'd0) && st_valid[s] && st_wen[s]
                && (st_rd[s] == st_rs1[1])) begin
                fwd1    = 1'b1;
                ex_reg1 = stage_wdata[(s-1)*XLEN +: XLEN];
            end
            if (!fwd2 && st_use_rs2[1] && (st_rs2[1] != 5'd0) && st_valid[s] && st_wen[s]
                && (st_rd[s] == st_rs2[1])) begin
                fwd2    = 1'b1;
                ex_reg2 = stage_wdata[(s-1)*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid <= '0;
            for (int unsigned s = 1; s <= NSTAGES; s++) begin
                st_wen[s]     <= 1'b0;
                st_is_load[s] <= 1'b0;
                st_use_rs1[s] <= 1'b0;
                st_use_rs2[s] <= 1'b0;
                st_rd[s]      <= '0;
                st_rs1[s]     <= '0;
                st_rs2[s]     <= '0;
            end
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (pipeline_en) begin
            for (int unsigned s = 2; s <= NSTAGES; s++) begin
                st_valid[s]   <= st_valid[s-1];
                st_wen[s]     <= st_wen[s-1];
                st_is_load[s] <= st_is_load[s-1];
                st_use_rs1[s] <= st_use_rs1[s-1];
                st_use_rs2[s] <= st_use_rs2[s-1];
                st_rd[s]      <= st_rd[s-1];
                st_rs1[s]     <= st_rs1[s-1];
                st_rs2[s]     <= st_rs2[s-1];
            end
            if (id_accept) begin
                st_valid[1]   <= 1'b1;
                st_wen[1]     <= id_wen;
                st_is_load[1] <= id_is_load;
                st_use_rs1[1] <= id_use_rs1;
                st_use_rs2[1] <= id_use_rs2;
                st_rd[1]      <= id_rd;
                st_rs1[1]     <= id_rs1;
                st_rs2[1]     <= id_rs2;
            end else begin
                st_valid[1]   <= 1'b0;
                st_wen[1]     <= 1'b0;
                st_is_load[1] <= 1'b0;
                st_use_rs1[1] <= 1'b0;
                st_use_rs2[1] <= 1'b0;
                st_rd[1]      <= '0;
                st_rs1[1]     <= '0;
                st_rs2[1]     <= '0;
            end
            if (id_stall) stall_cnt <= stall_cnt + CNT_W'(1);
            if (id_flush) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against an instruction-level model of the pipeline.
module tb_pipe_hazard_ctrl;

    localparam int N        = 3;
    localparam int XL       = 32;
    localparam int ALU_RDY  = 2;
    localparam int LOAD_RDY = 3;

    typedef struct packed {
        logic       valid;
        logic       wen;
        logic       is_load;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            icache_valid, dcache_valid;
    logic            id_valid;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2, id_wen, id_is_load;
    logic            ex_redirect;
    logic [XL-1:0]   ex_reg1_rf, ex_reg2_rf;
    logic [N*XL-1:0] stage_wdata;

    logic            pipeline_en, id_stall, id_flush, wb_wen;
    logic [XL-1:0]   ex_reg1, ex_reg2;
    logic [N-1:0]    stage_valid;
    logic [4:0]      wb_rd;
    logic [31:0]     stall_cnt, flush_cnt;

    logic            d_pipeline_en, d_id_stall, d_id_flush, d_wb_wen;
    logic [XL-1:0]   d_ex_reg1, d_ex_reg2;
    logic [1:0]      d_stage_valid;
    logic [4:0]      d_wb_rd;
    logic [31:0]     d_stall_cnt, d_flush_cnt;

    ent_t        m [1:N];
    logic [31:0] m_stall_cnt, m_flush_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NSTAGES(N), .XLEN(XL), .ALU_LAT(ALU_RDY), .LOAD_LAT(LOAD_RDY), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .icache_valid(icache_valid), .dcache_valid(dcache_valid),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .ex_reg1_rf(ex_reg1_rf), .ex_reg2_rf(ex_reg2_rf), .stage_wdata(stage_wdata),
        .pipeline_en(pipeline_en), .id_stall(id_stall), .id_flush(id_flush),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .stage_valid(stage_valid),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl dut_def (
        .clk(clk), .rst(rst), .icache_valid(icache_valid), .dcache_valid(dcache_valid),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .ex_reg1_rf(ex_reg1_rf), .ex_reg2_rf(ex_reg2_rf), .stage_wdata(stage_wdata[2*XL-1:0]),
        .pipeline_en(d_pipeline_en), .id_stall(d_id_stall), .id_flush(d_id_flush),
        .ex_reg1(d_ex_reg1), .ex_reg2(d_ex_reg2), .stage_valid(d_stage_valid),
        .wb_wen(d_wb_wen), .wb_rd(d_wb_rd), .stall_cnt(d_stall_cnt), .flush_cnt(d_flush_cnt)
    );

    // ---------------- reference model (instruction level) ----------------
    function automatic logic exp_flush();
        return id_valid && ex_redirect && m[1].valid;
    endfunction

    // A producer at stage s reaches its result stage after (rdy - s) cycles; the
    // consumer reaches EX after one cycle and needs the producer at rdy or beyond.
    function automatic logic src_blocked(logic u, logic [4:0] r);
        if (!u || r == 5'd0) return 1'b0;
        for (int s = 1; s < N; s++) begin
            if (m[s].valid && m[s].wen && m[s].rd == r) begin
                int rdy;
                rdy = m[s].is_load ? LOAD_RDY : ALU_RDY;
                return (rdy - s) > 1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic exp_stall();
        return id_valid && !(ex_redirect && m[1].valid)
               && (src_blocked(id_use_rs1, id_rs1) || src_blocked(id_use_rs2, id_rs2));
    endfunction

    function automatic logic [XL-1:0] exp_fwd(logic u, logic [4:0] r, logic [XL-1:0] rf);
        if (u && r != 5'd0) begin
            for (int s = 2; s <= N; s++)
                if (m[s].valid && m[s].wen && m[s].rd == r) return stage_wdata[(s-1)*XL +: XL];
        end
        return rf;
    endfunction

    function automatic logic [N-1:0] exp_valid();
        logic [N-1:0] v;
        for (int s = 1; s <= N; s++) v[s-1] = m[s].valid;
        return v;
    endfunction

    task automatic tick();
        logic en, st, fl;
        ent_t e;
        en = icache_valid && dcache_valid;
        st = exp_stall();
        fl = exp_flush();
        e  = '{valid: 1'b1, wen: id_wen, is_load: id_is_load, use1: id_use_rs1, use2: id_use_rs2,
               rd: id_rd, rs1: id_rs1, rs2: id_rs2};
        @(posedge clk);
        if (rst) begin
            for (int s = 1; s <= N; s++) m[s] = '0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
        end else if (en) begin
            for (int s = N; s >= 2; s--) m[s] = m[s-1];
            m[1] = (id_valid && !st && !fl) ? e : ent_t'('0);
            if (st) m_stall_cnt = m_stall_cnt + 32'd1;
            if (fl) m_flush_cnt = m_flush_cnt + 32'd1;
        end
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        icache_valid = 1'b1; dcache_valid = 1'b1;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_wen = 1'b0; id_is_load = 1'b0;
        ex_redirect = 1'b0; ex_reg1_rf = '0; ex_reg2_rf = '0; stage_wdata = '0;
    endtask

    task automatic set_id(logic [4:0] rd, logic load, logic u1, logic [4:0] r1, logic u2, logic [4:0] r2);
        id_valid = 1'b1; id_rd = rd; id_wen = 1'b1; id_is_load = load;
        id_use_rs1 = u1; id_rs1 = r1; id_use_rs2 = u2; id_rs2 = r2;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        set_id(5'd3, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0);
        ex_redirect = 1'b1;
        @(negedge clk);
        checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL reset stage_valid got %b exp 000", stage_valid); end
        checks++; if (wb_wen !== 1'b0 || wb_rd !== 5'd0) begin errors++; $display("FAIL reset wb got wen=%b rd=%0d exp 0/0", wb_wen, wb_rd); end
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL reset counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        checks++; if (id_stall !== 1'b0 || id_flush !== 1'b0) begin errors++; $display("FAIL reset stall_flush got %b%b exp 00", id_stall, id_flush); end
        idle();
    endtask

    task automatic test_default_bypass();
        do_reset();
        set_id(5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        set_id(5'd6, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5);
        @(negedge clk);
        checks++; if (d_id_stall !== 1'b0) begin errors++; $display("FAIL def_stall got %b exp 0", d_id_stall); end
        tick();
        idle();
        stage_wdata[2*XL-1:XL] = 32'd7;
        stage_wdata[XL-1:0]    = 32'h99;
        @(negedge clk);
        checks++; if (d_ex_reg1 !== 32'd7) begin errors++; $display("FAIL def_ex_reg1 got %h exp 7", d_ex_reg1); end
        checks++; if (d_ex_reg2 !== 32'd7) begin errors++; $display("FAIL def_ex_reg2 got %h exp 7", d_ex_reg2); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        set_id(5'd7, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", id_stall); end
        tick();
        @(negedge clk);
        checks++; if (stage_valid !== 3'b010) begin errors++; $display("FAIL lu_bubble stage_valid got %b exp 010", stage_valid); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", id_stall); end
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
        tick();
        idle();
        stage_wdata[3*XL-1:2*XL] = 32'hDEADBEEF;
        ex_reg1_rf = 32'h1234;
        @(negedge clk);
        checks++; if (ex_reg1 !== 32'hDEADBEEF) begin errors++; $display("FAIL lu_fwd got %h exp deadbeef", ex_reg1); end
    endtask

    task automatic test_youngest_wins();
        for (int pass = 0; pass < 2; pass++) begin
            logic [4:0] r;
            r = (pass == 0) ? 5'd9 : 5'd0;
            do_reset();
            set_id(r, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
            tick();
            tick();
            set_id(5'd10, 1'b0, 1'b1, r, 1'b0, 5'd9);
            tick();
            idle();
            stage_wdata = {32'd2, 32'd1, 32'hFFFF};
            ex_reg1_rf  = 32'h55;
            ex_reg2_rf  = 32'h66;
            @(negedge clk);
            if (pass == 0) begin
                checks++; if (ex_reg1 !== 32'd1) begin errors++; $display("FAIL youngest got %h exp 1", ex_reg1); end
            end else begin
                checks++; if (ex_reg1 !== 32'h55) begin errors++; $display("FAIL x0_nofwd got %h exp 55", ex_reg1); end
            end
            checks++; if (ex_reg2 !== 32'h66) begin errors++; $display("FAIL unused_rs2 got %h exp 66", ex_reg2); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        set_id(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        set_id(5'd6, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        ex_redirect = 1'b1;
        @(negedge clk);
        checks++; if (id_flush !== 1'b1 || id_stall !== 1'b0) begin errors++; $display("FAIL rd_prio got flush=%b stall=%b exp 1/0", id_flush, id_stall); end
        tick();
        @(negedge clk);
        checks++; if (stage_valid !== 3'b010) begin errors++; $display("FAIL rd_bubble got %b exp 010", stage_valid); end
        checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin errors++; $display("FAIL rd_cnt got %0d/%0d exp 1/0", flush_cnt, stall_cnt); end
        checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL rd_ignored got %b exp 0", id_flush); end
        tick();
        @(negedge clk);
        checks++; if (stage_valid !== 3'b101 || flush_cnt !== 32'd1) begin errors++; $display("FAIL rd_after got %b/%0d exp 101/1", stage_valid, flush_cnt); end
        idle();
    endtask

    task automatic test_freeze();
        do_reset();
        set_id(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        set_id(5'd8, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5);
        dcache_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (pipeline_en !== 1'b0 || id_stall !== 1'b1) begin errors++; $display("FAIL frz_ctl cyc %0d got en=%b stall=%b exp 0/1", i, pipeline_en, id_stall); end
            tick();
            @(negedge clk);
            checks++; if (stage_valid !== 3'b001 || stall_cnt !== 32'd0) begin errors++; $display("FAIL frz_hold cyc %0d got %b/%0d exp 001/0", i, stage_valid, stall_cnt); end
        end
        dcache_valid = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (stage_valid !== 3'b010 || stall_cnt !== 32'd1 || id_stall !== 1'b0) begin errors++; $display("FAIL frz_resume got %b/%0d/%b exp 010/1/0", stage_valid, stall_cnt, id_stall); end
        tick();
        @(negedge clk);
        checks++; if (stage_valid !== 3'b101) begin errors++; $display("FAIL frz_done got %b exp 101", stage_valid); end
        idle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_id(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        set_id(5'd6, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        tick();
        tick();
        set_id(5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        tick();
        @(negedge clk);
        checks++; if (stage_valid !== 3'b111 || stall_cnt !== 32'd1) begin errors++; $display("FAIL mr_pre got %b/%0d exp 111/1", stage_valid, stall_cnt); end
        set_id(5'd9, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (stage_valid !== 3'b000 || wb_wen !== 1'b0) begin errors++; $display("FAIL mr_state got %b/%b exp 000/0", stage_valid, wb_wen); end
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || id_stall !== 1'b0) begin errors++; $display("FAIL mr_cnt got %0d/%0d/%b exp 0/0/0", stall_cnt, flush_cnt, id_stall); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic          e_st, e_fl;
            logic [XL-1:0] e_r1, e_r2;
            rst          = ($urandom_range(0, 99) < 2);
            icache_valid = ($urandom_range(0, 9) != 0);
            dcache_valid = ($urandom_range(0, 9) != 0);
            id_valid     = ($urandom_range(0, 4) != 0);
            id_rs1       = 5'($urandom_range(0, 6));
            id_rs2       = 5'($urandom_range(0, 6));
            id_rd        = 5'($urandom_range(0, 6));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            id_wen       = ($urandom_range(0, 3) != 0);
            id_is_load   = ($urandom_range(0, 9) < 4);
            ex_redirect  = ($urandom_range(0, 9) < 1);
            ex_reg1_rf   = $urandom;
            ex_reg2_rf   = $urandom;
            stage_wdata  = {$urandom, $urandom, $urandom};
            @(negedge clk);
            e_st = exp_stall();
            e_fl = exp_flush();
            e_r1 = exp_fwd(m[1].use1, m[1].rs1, ex_reg1_rf);
            e_r2 = exp_fwd(m[1].use2, m[1].rs2, ex_reg2_rf);
            checks++; if (id_stall !== e_st) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", i, id_stall, e_st); end
            checks++; if (id_flush !== e_fl) begin errors++; $display("FAIL rnd_flush cyc %0d got %b exp %b", i, id_flush, e_fl); end
            checks++; if (pipeline_en !== (icache_valid && dcache_valid)) begin errors++; $display("FAIL rnd_en cyc %0d got %b", i, pipeline_en); end
            checks++; if (ex_reg1 !== e_r1) begin errors++; $display("FAIL rnd_ex_reg1 cyc %0d got %h exp %h", i, ex_reg1, e_r1); end
            checks++; if (ex_reg2 !== e_r2) begin errors++; $display("FAIL rnd_ex_reg2 cyc %0d got %h exp %h", i, ex_reg2, e_r2); end
            checks++; if (stage_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, stage_valid, exp_valid()); end
            checks++; if (wb_wen !== (m[N].valid && m[N].wen) || wb_rd !== m[N].rd) begin errors++; $display("FAIL rnd_wb cyc %0d got %b/%0d exp %b/%0d", i, wb_wen, wb_rd, m[N].valid && m[N].wen, m[N].rd); end
            checks++; if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", i, stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt); end
            checks++; if (d_id_stall !== 1'b0) begin errors++; $display("FAIL rnd_def_nostall cyc %0d got %b", i, d_id_stall); end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_default_bypass();
        test_load_use();
        test_youngest_wins();
        test_redirect();
        test_freeze();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control for the in-order RV32 core.
- Replaces the single global enable and single WB→EX bypass with the following:
  - per-stage valid tracking across NSTAGES post-decode stages;
  - a load-use/latency interlock that stalls ID and inserts a bubble;
  - redirect flush of ID;
  - youngest-first operand forwarding from every stage 2..NSTAGES into EX.
- Sits between decoder/regfile (ID) and the EX datapath.
- Owns the in-flight rd/wen/latency shift register.

Parameters:
- NSTAGES, 2, post-decode stages (1=EX, NSTAGES=WB); range 2..6.
- XLEN, 32, data width.
- ALU_LAT, 2, first stage index whose stage_wdata holds a non-load result; range 2..NSTAGES.
- LOAD_LAT, 2, first stage index whose stage_wdata holds load data; range ALU_LAT..NSTAGES.
- CNT_W, 32, width of stall/flush counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- icache_valid  in  1  fetch data valid; 0 freezes whole pipeline
- dcache_valid  in  1  dcache ready; 0 freezes whole pipeline
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5  ID source registers
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_rd  in  5  ID destination
- id_wen  in  1  ID writes rd
- id_is_load  in  1  ID is a load
- ex_redirect  in  1  EX instruction resolved a PC different from prediction
- ex_reg1_rf, ex_reg2_rf  in  XLEN  operands latched from regfile in ID
- stage_wdata  in  NSTAGES*XLEN  result of stage s at slice [(s-1)*XLEN +: XLEN]
- pipeline_en  out  1  all pipeline registers advance
- id_stall  out  1  hold IF/ID, bubble into EX
- id_flush  out  1  ID instruction discarded, bubble into EX
- ex_reg1, ex_reg2  out  XLEN  forwarded EX operands
- stage_valid  out  NSTAGES  valid bit of each stage
- wb_wen  out  1  stage NSTAGES valid && wen
- wb_rd  out  5  stage NSTAGES rd
- stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- Reset: all stage entries zeroed (valid=0, wen=0, rd=0); counters 0. stage_valid=0, wb_wen=0, wb_rd=0. id_stall and id_flush are 0 at reset because stage 1 is invalid and ex_redirect is qualified by stage_valid[1]. Reset overrides pipeline_en.
- pipeline_en = icache_valid && dcache_valid. When 0, no internal state or counter changes.
- Entry per stage: {valid, rd, wen, is_load, use_rs1, use_rs2, rs1, rs2}. Only the stage-1 rs fields are consumed.
- redirect = ex_redirect && stage_valid[1].
- id_flush = id_valid && redirect.
- Hazard: ID source r (use && r!=0) matches stage s (valid, wen, rd==r, 1<=s<NSTAGES). Only the youngest matching s counts. The hazard holds if s+1 < (is_load ? LOAD_LAT : ALU_LAT).
- Producers in stage NSTAGES are not checked. reg_file write-first read covers them.
- id_stall = id_valid && hazard && !redirect. Combinational, with no added latency.
- Advance when pipeline_en:
  - stage[s] <= stage[s-1] for s>=2;
  - stage[1] <= ID entry if id_valid && !id_stall && !id_flush, else a bubble (valid=0, wen=0).
- Priority: freeze > redirect flush > interlock stall.
- Forwarding for EX operand k, applied only if the EX entry uses rs_k and rs_k!=0:
  - the youngest stage s in 2..NSTAGES with valid, wen, rd==rs_k supplies its stage_wdata slice;
  - otherwise ex_regk_rf is used;
  - x0 is never forwarded.
  - The interlock guarantees the selected slice is already valid data.
- stall_cnt increments on each enabled cycle with id_stall=1; flush_cnt on each enabled cycle with id_flush=1. Both wrap modulo 2^CNT_W.
- Defaults (NSTAGES=2, ALU_LAT=LOAD_LAT=2) never stall and reproduce the existing WB→EX bypass exactly.

Test Plan:
1. Defaults: addi x5 in EX, add x6,x5,x5 in ID → id_stall=0. Next cycle stage_wdata[2] has 7, so ex_reg1=ex_reg2=7 while ex_reg1_rf=0.
2. NSTAGES=3, LOAD_LAT=3: lw x5 in EX, consumer of x5 in ID → id_stall=1 for exactly 1 cycle, stage_valid=3'b010 after the bubble, stall_cnt=1. Consumer then gets load data 0xDEADBEEF from stage 3.
3. Stages 2 and 3 both write x9 (values 1, 2), EX reads x9 → ex_reg1=1 (youngest wins). With rd=x0 in both, ex_reg1=ex_reg1_rf.
4. ex_redirect=1 with stage_valid[1]=1 and a hazard present → id_flush=1, id_stall=0, bubble enters EX, flush_cnt=1. ex_redirect=1 with stage_valid[1]=0 → ignored.
5. dcache_valid=0 for 3 cycles during a stall → stage_valid and counters unchanged. The stall resumes and resolves after dcache_valid returns.
6. rst asserted mid-stream with all stages valid → next cycle stage_valid=0, wb_wen=0, counters=0, id_stall=0.
